// File: rtl/present_cbc_ctrl.sv
// present_cbc_ctrl: block controller placed in front of the PRESENT cipher core.
// It accepts 64-bit plaintext blocks on a valid/ready stream and launches the
// core with a one-cycle start pulse. When the core completes, it captures the
// ciphertext and presents it on a valid/ready output stream. A sticky err flag
// is raised if the core does not complete within TIMEOUT_CYCLES WAIT cycles.
//
// Build option: define PRESENT_CBC_EN to select CBC mode. In CBC mode each
// block is XORed with the chaining value and the chain follows the ciphertext.
// When the macro is undefined the block runs in ECB mode and iv is ignored.
//
// Ports:
//   CK, RN                  clock, asynchronous active-low reset
//   load, key_in, iv        key/IV load, honoured only in IDLE; also clears err
//   in_valid/in_ready/in_data     plaintext stream
//   out_valid/out_ready/out_data  ciphertext stream
//   core_start/core_ptext/core_key  core request
//   core_ready/core_ctext           core response
//   busy, err               status: not idle; sticky timeout flag
module present_cbc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        load,
  input  logic [79:0] key_in,
  input  logic [63:0] iv,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic        core_start,
  output logic [63:0] core_ptext,
  output logic [79:0] core_key,
  input  logic        core_ready,
  input  logic [63:0] core_ctext,
  output logic        busy,
  output logic        err
);

  localparam int unsigned KEY_W = 80;
  localparam int unsigned BLK_W = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t             state, state_n;
  logic [KEY_W-1:0]   key_reg;
  logic [BLK_W-1:0]   blk_reg;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               armed;

  // Control decodes produced by the next-state logic
  logic do_load, do_acc, do_cap, do_tmo, do_ack;

`ifdef PRESENT_CBC_EN
  logic [BLK_W-1:0] chain_reg;
`else
  logic unused_iv;
  assign unused_iv = ^iv;
`endif

  // State register
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and control decode
  always_comb begin
    state_n = state;
    do_load = 1'b0;
    do_acc  = 1'b0;
    do_cap  = 1'b0;
    do_tmo  = 1'b0;
    do_ack  = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          do_load = 1'b1;
        end else if (in_valid) begin
          do_acc  = 1'b1;
          state_n = S_START;
        end
      end
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        // armed keeps a ready level left over from the previous block from
        // counting as completion; completion beats timeout in the same cycle
        if (armed && core_ready) begin
          do_cap  = 1'b1;
          state_n = S_OUT;
        end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          do_tmo  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          do_ack  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath, counter and status registers
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      key_reg   <= '0;
      blk_reg   <= '0;
      tmo_cnt   <= '0;
      armed     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
`ifdef PRESENT_CBC_EN
      chain_reg <= '0;
`endif
    end else begin
      if (do_load) begin
        key_reg <= key_in;
        err     <= 1'b0;
`ifdef PRESENT_CBC_EN
        chain_reg <= iv;
`endif
      end
      if (do_acc) begin
`ifdef PRESENT_CBC_EN
        blk_reg <= in_data ^ chain_reg;
`else
        blk_reg <= in_data;
`endif
      end
      if (state == S_START) begin
        tmo_cnt <= '0;
        armed   <= 1'b0;
      end
      if (state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
        if (!core_ready) armed <= 1'b1;
      end
      if (do_cap) begin
        out_data  <= core_ctext;
        out_valid <= 1'b1;
`ifdef PRESENT_CBC_EN
        chain_reg <= core_ctext;
`endif
      end
      if (do_tmo) err <= 1'b1;
      if (do_ack) out_valid <= 1'b0;
    end
  end

  // State decodes; in_ready is gated by RN so every output reads 0 in reset
  assign in_ready   = RN && (state == S_IDLE) && !load;
  assign core_start = (state == S_START);
  assign busy       = (state != S_IDLE);
  assign core_ptext = blk_reg;
  assign core_key   = key_reg;

endmodule

// File: tb/tb_present_cbc_ctrl.sv
// Testbench for present_cbc_ctrl. It includes a behavioural PRESENT-80 core
// stub with programmable latency, a stale-ready option and a hang option.
// Expected ciphertexts come from a reference model of the block chain.
module tb_present_cbc_ctrl;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        load = 1'b0;
  logic [79:0] key_in = '0;
  logic [63:0] iv = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready = 1'b0;
  logic        core_start;
  logic [63:0] core_ptext;
  logic [79:0] core_key;
  logic        core_ready;
  logic [63:0] core_ctext;
  logic        busy;
  logic        err;

  present_cbc_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .CK(CK), .RN(RN), .load(load), .key_in(key_in), .iv(iv),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_start(core_start), .core_ptext(core_ptext), .core_key(core_key),
    .core_ready(core_ready), .core_ctext(core_ctext),
    .busy(busy), .err(err)
  );

  always #5 CK = ~CK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  // PRESENT-80 encryption: 31 rounds plus a final key whitening
  function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s, p;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int i = 0; i < 16; i++) s[4*i +: 4] = sb(s[4*i +: 4]);
      p = '0;
      for (int i = 0; i < 63; i++) p[(i*16) % 63] = s[i];
      p[63] = s[63];
      s = p;
      k = {k[18:0], k[79:19]};
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Core stub. Ready stays high after a completed operation, which creates the stale-ready case.
  int          lat_cfg = 4;
  bit          hang_cfg = 1'b0;
  bit          stale_cfg = 1'b0;
  int          s_cnt;
  bit          s_act;
  logic [63:0] s_pend;

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      s_act      <= 1'b0;
      s_cnt      <= 0;
      core_ready <= 1'b1;
      core_ctext <= '0;
      s_pend     <= '0;
    end else if (core_start) begin
      s_act  <= 1'b1;
      s_cnt  <= 0;
      s_pend <= present80(core_ptext, core_key);
      if (!stale_cfg) core_ready <= 1'b0;
    end else if (s_act) begin
      s_cnt <= s_cnt + 1;
      if (s_cnt == 0) core_ready <= 1'b0;
      if (!hang_cfg && (s_cnt + 1 == lat_cfg)) begin
        core_ready <= 1'b1;
        core_ctext <= s_pend;
        s_act      <= 1'b0;
      end
    end
  end

  int n_start = 0;
  always @(posedge CK) if (RN && core_start) n_start <= n_start + 1;

  // Reference model state
  logic [79:0] m_key = '0;
  logic [63:0] m_chain = '0;

  task automatic do_load(input logic [79:0] k, input logic [63:0] v);
    @(negedge CK);
    load = 1'b1; key_in = k; iv = v;
    #1 chk("load_in_ready", 80'(in_ready), 80'(0));
    @(negedge CK);
    load = 1'b0;
    m_key = k;
    m_chain = v;
    chk("load_err_clr", 80'(err), 80'(0));
    chk("load_key", 80'(core_key), k);
  endtask

  task automatic send_block(input logic [63:0] d, input int lat, input int bp,
                            output logic [63:0] got);
    logic [63:0] exp, held;
    int n, s0;
    lat_cfg = lat;
`ifdef PRESENT_CBC_EN
    exp = present80(d ^ m_chain, m_key);
`else
    exp = present80(d, m_key);
`endif
    @(negedge CK);
    chk("idle_in_ready", 80'(in_ready), 80'(1));
    in_valid = 1'b1; in_data = d; s0 = n_start;
    @(negedge CK);
    in_valid = 1'b0; in_data = {$urandom, $urandom};
    chk("start_pulse", 80'(core_start), 80'(1));
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge CK);
      n++;
    end
    chk("latency", 80'(n), 80'(lat + 2));
    chk("out_data", 80'(out_data), 80'(exp));
    got = out_data;
    held = out_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge CK);
      chk("bp_valid", 80'(out_valid), 80'(1));
      chk("bp_data", 80'(out_data), 80'(held));
      chk("bp_in_ready", 80'(in_ready), 80'(0));
    end
    chk("one_start", 80'(n_start - s0), 80'(1));
    out_ready = 1'b1;
    @(negedge CK);
    out_ready = 1'b0;
    chk("ack_valid_clr", 80'(out_valid), 80'(0));
    chk("ack_idle", 80'(busy), 80'(0));
    chk("ack_in_ready", 80'(in_ready), 80'(1));
`ifdef PRESENT_CBC_EN
    m_chain = exp;
`endif
  endtask

  task automatic run_timeout();
    int n;
    bit seen_ov;
    hang_cfg = 1'b1;
    @(negedge CK);
    in_valid = 1'b1; in_data = {$urandom, $urandom};
    @(negedge CK);
    in_valid = 1'b0;
    n = 0;
    seen_ov = 1'b0;
    while (busy && n < 300) begin
      @(negedge CK);
      n++;
      if (out_valid) seen_ov = 1'b1;
    end
    chk("tmo_cycles", 80'(n), 80'(65));
    chk("tmo_err", 80'(err), 80'(1));
    chk("tmo_no_out", 80'(seen_ov), 80'(0));
    hang_cfg = 1'b0;
  endtask

  initial begin
    logic [63:0] got;
    #1;
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(0));
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_core_start", 80'(core_start), 80'(0));
    chk("rst_err", 80'(err), 80'(0));
    chk("rst_key", 80'(core_key), 80'(0));
    @(negedge CK); @(negedge CK);
    RN = 1'b1;

    // Known-answer tests
`ifdef PRESENT_CBC_EN
    do_load(80'h0, 64'h0);
    send_block(64'h0, 3, 0, got);
    chk("kat_cbc0", 80'(got), 80'(64'h5579C1387B228445));
    send_block(64'h5579C1387B228445, 3, 0, got);
    chk("kat_cbc1", 80'(got), 80'(64'h5579C1387B228445));
    do_load(80'h0, 64'hFFFFFFFFFFFFFFFF);
    send_block(64'h0, 3, 0, got);
    chk("kat_cbc_iv", 80'(got), 80'(64'hA112FFC72F68417B));
`else
    do_load(80'h0, 64'h0123456789ABCDEF);
    send_block(64'h0, 3, 0, got);
    chk("kat_ecb0", 80'(got), 80'(64'h5579C1387B228445));
    do_load(80'hFFFFFFFFFFFFFFFFFFFF, 64'h0);
    send_block(64'hFFFFFFFFFFFFFFFF, 3, 0, got);
    chk("kat_ecb1", 80'(got), 80'(64'h3333DCD3213210D2));
`endif

    // Backpressure for 10 cycles
    send_block({$urandom, $urandom}, 5, 10, got);

    // Stale ready: drop one cycle late, rise 32 cycles after start
    stale_cfg = 1'b1;
    send_block({$urandom, $urandom}, 32, 0, got);
    stale_cfg = 1'b0;

    // Randomized traffic with occasional reloads
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 3) == 0)
        do_load({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom});
      send_block({$urandom, $urandom}, int'($urandom_range(2, 12)),
                 int'($urandom_range(0, 3)), got);
    end

    // Timeout, then load clears err; chain survives the dropped block
    run_timeout();
    do_load({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom});
    send_block({$urandom, $urandom}, 4, 1, got);
    run_timeout();
    send_block({$urandom, $urandom}, 6, 0, got);

    // Reset during WAIT: outputs clear asynchronously
    lat_cfg = 20;
    @(negedge CK);
    in_valid = 1'b1; in_data = {$urandom, $urandom};
    @(negedge CK);
    in_valid = 1'b0;
    repeat (5) @(negedge CK);
    #2 RN = 1'b0;
    #1;
    chk("arst_busy", 80'(busy), 80'(0));
    chk("arst_err", 80'(err), 80'(0));
    chk("arst_out_valid", 80'(out_valid), 80'(0));
    chk("arst_out_data", 80'(out_data), 80'(0));
    chk("arst_core_start", 80'(core_start), 80'(0));
    chk("arst_ptext", 80'(core_ptext), 80'(0));
    chk("arst_key", 80'(core_key), 80'(0));
    chk("arst_in_ready", 80'(in_ready), 80'(0));
    @(negedge CK);
    RN = 1'b1;

    // load and in_valid together: load wins, no block accepted
    @(negedge CK);
    load = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom};
    key_in = 80'h0123456789ABCDEF0123; iv = 64'h0F0F0F0F0F0F0F0F;
    #1 chk("prio_in_ready", 80'(in_ready), 80'(0));
    @(negedge CK);
    load = 1'b0; in_valid = 1'b0;
    chk("prio_idle", 80'(busy), 80'(0));
    chk("prio_no_start", 80'(core_start), 80'(0));
    chk("prio_key", 80'(core_key), 80'h0123456789ABCDEF0123);
    m_key = 80'h0123456789ABCDEF0123;
    m_chain = 64'h0F0F0F0F0F0F0F0F;
    send_block({$urandom, $urandom}, 5, 2, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
